// File: rtl/game_ctl.sv
// ============================================================================
// game_ctl
// ----------------------------------------------------------------------------
// Match sequencer for the PONG top level. Runs the match flow
// IDLE -> SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER) -> IDLE.
// It also owns both score counters and tells the ball controller when the
// ball may move and when it is held at the screen centre. All timing inside
// a rally is counted in video frames via frame_tick.
//
// Parameters
//   WIN_SCORE     score that ends the match (1..99)
//   SERVE_FRAMES  frames the ball is held centred before a serve (1..255)
//   POINT_FRAMES  frames the ball is frozen after a miss (1..255)
//
// Ports
//   clk                   in   pixel clock, rising edge
//   rst                   in   synchronous active-high reset
//   frame_tick            in   one-cycle pulse per video frame
//   btn_up, btn_down      in   debounced button levels; either one rising starts
//   miss_left             in   pulse, player 1 missed (player 2 scores)
//   miss_right            in   pulse, player 2 missed (player 1 scores)
//   ball_run              out  ball controller may move the ball
//   ball_reset            out  ball controller holds the ball at the centre
//   serve_dir             out  0 = serve toward left, 1 = toward right
//   points_first_player   out  player-1 score, binary
//   points_second_player  out  player-2 score, binary
//   game_over             out  high while the match is finished
//   winner                out  0 = player 1, 1 = player 2, valid with game_over
//   state_dbg             out  encoded state for debug
// ============================================================================
module game_ctl #(
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [6:0] points_first_player,
    output logic [6:0] points_second_player,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [6:0] SCORE_MAX  = 7'(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_nxt;
    logic [6:0] p1_nxt;
    logic [6:0] p2_nxt;
    logic       serve_dir_nxt;
    logic       winner_nxt;
    logic       ball_run_nxt;
    logic       ball_reset_nxt;
    logic       game_over_nxt;
    logic       btn_prev;
    logic       btn_any;
    logic       start_evt;

    assign btn_any   = btn_up | btn_down;
    assign start_evt = btn_any & ~btn_prev;
    assign state_dbg = state;

    // Register every piece of state and every output. The button history
    // register keeps following the buttons even while reset is held, so a
    // button that is already pressed when reset releases looks like a
    // steady level rather than a fresh press and cannot start a match.
    always_ff @(posedge clk) begin
        btn_prev <= btn_any;
        if (rst) begin
            state                <= IDLE;
            frame_cnt            <= 8'd0;
            points_first_player  <= 7'd0;
            points_second_player <= 7'd0;
            serve_dir            <= 1'b0;
            winner               <= 1'b0;
            ball_run             <= 1'b0;
            ball_reset           <= 1'b1;
            game_over            <= 1'b0;
        end else begin
            state                <= state_nxt;
            frame_cnt            <= frame_cnt_nxt;
            points_first_player  <= p1_nxt;
            points_second_player <= p2_nxt;
            serve_dir            <= serve_dir_nxt;
            winner               <= winner_nxt;
            ball_run             <= ball_run_nxt;
            ball_reset           <= ball_reset_nxt;
            game_over            <= game_over_nxt;
        end
    end

    // Next-state and next-output logic. Frame ticks are counted only while
    // serving or frozen after a point. A phase ends on the tick that brings
    // the count up to its frame budget, so the count compares against
    // budget-1. miss_left is tested first, so it takes priority when both
    // edges fire together. The ball control outputs are decoded from the
    // next state. That way they flip on the same edge as the state and the
    // score, and ball_run drops together with the score update.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        p1_nxt        = points_first_player;
        p2_nxt        = points_second_player;
        serve_dir_nxt = serve_dir;
        winner_nxt    = winner;

        case (state)
            IDLE: begin
                if (start_evt) begin
                    p1_nxt        = 7'd0;
                    p2_nxt        = 7'd0;
                    serve_dir_nxt = 1'b0;
                    state_nxt     = SERVE;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt == SERVE_LAST) begin
                        state_nxt = PLAY;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
            end
            PLAY: begin
                if (miss_left) begin
                    if (points_second_player < SCORE_MAX) begin
                        p2_nxt = points_second_player + 7'd1;
                    end
                    serve_dir_nxt = 1'b0;
                    state_nxt     = POINT;
                end else if (miss_right) begin
                    if (points_first_player < SCORE_MAX) begin
                        p1_nxt = points_first_player + 7'd1;
                    end
                    serve_dir_nxt = 1'b1;
                    state_nxt     = POINT;
                end
            end
            POINT: begin
                if (frame_tick) begin
                    if (frame_cnt == POINT_LAST) begin
                        if ((points_first_player == SCORE_MAX) ||
                            (points_second_player == SCORE_MAX)) begin
                            state_nxt  = GAME_OVER;
                            winner_nxt = (points_second_player == SCORE_MAX);
                        end else begin
                            state_nxt = SERVE;
                        end
                    end else begin
                        frame_cnt_nxt = frame_cnt + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start_evt) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) begin
            frame_cnt_nxt = 8'd0;
        end

        ball_run_nxt   = (state_nxt == PLAY);
        ball_reset_nxt = (state_nxt == IDLE) || (state_nxt == SERVE) ||
                         (state_nxt == GAME_OVER);
        game_over_nxt  = (state_nxt == GAME_OVER);
    end

endmodule

// File: tb/tb_game_ctl.sv
// ============================================================================
// tb_game_ctl
// ----------------------------------------------------------------------------
// Directed testbench for game_ctl with default parameters (11 / 60 / 90).
// The stimulus process drives the inputs one clock at a time. It queues the
// output snapshot expected once the edge that sampled those inputs has gone
// by. A separate monitor compares each queued snapshot with the DUT outputs
// on the falling edge of that cycle.
// ============================================================================
module tb_game_ctl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    typedef struct packed {
        logic       run;
        logic       breset;
        logic       dir;
        logic [6:0] p1;
        logic [6:0] p2;
        logic       over;
        logic       win;
        logic [2:0] st;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic       ball_run;
    logic       ball_reset;
    logic       serve_dir;
    logic [6:0] points_first_player;
    logic [6:0] points_second_player;
    logic       game_over;
    logic       winner;
    logic [2:0] state_dbg;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc_q[$];
    out_t  exp_q[$];
    string name_q[$];

    int e_p1;
    int e_p2;
    int e_dir;

    game_ctl dut (
        .clk                  (clk),
        .rst                  (rst),
        .frame_tick           (frame_tick),
        .btn_up               (btn_up),
        .btn_down             (btn_down),
        .miss_left            (miss_left),
        .miss_right           (miss_right),
        .ball_run             (ball_run),
        .ball_reset           (ball_reset),
        .serve_dir            (serve_dir),
        .points_first_player  (points_first_player),
        .points_second_player (points_second_player),
        .game_over            (game_over),
        .winner               (winner),
        .state_dbg            (state_dbg)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Count rising edges. Expectations are tagged with the edge number
    // they belong to.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one clock of inputs. Return shortly after the edge that
    // sampled them.
    task automatic applyStimulus(input logic up, input logic down,
                                 input logic ml, input logic mr,
                                 input logic ft);
        btn_up     = up;
        btn_down   = down;
        miss_left  = ml;
        miss_right = mr;
        frame_tick = ft;
        @(posedge clk);
        #1;
    endtask

    // Queue the expected outputs for the edge just taken. The ball control
    // and game_over levels follow from the state.
    task automatic checkOutput(input string name, input logic [2:0] st,
                               input int p1, input int p2,
                               input int dir, input logic win);
        out_t e;
        e.st     = st;
        e.run    = (st == S_PLAY);
        e.breset = (st == S_IDLE) || (st == S_SERVE) || (st == S_OVER);
        e.over   = (st == S_OVER);
        e.p1     = 7'(p1);
        e.p2     = 7'(p2);
        e.dir    = dir[0];
        e.win    = win;
        cyc_q.push_back(cyc);
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic tickFrames(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // One full rally from PLAY: a miss, the frozen point phase, the serve,
    // and back to PLAY. The score and serve direction follow the bench's
    // own bookkeeping.
    task automatic playPoint(input logic ml, input logic mr);
        applyStimulus(1'b0, 1'b0, ml, mr, 1'b0);
        if (ml) begin
            e_p2  = e_p2 + 1;
            e_dir = 0;
        end else begin
            e_p1  = e_p1 + 1;
            e_dir = 1;
        end
        checkOutput("rally_miss", S_POINT, e_p1, e_p2, e_dir, 1'b0);
        tickFrames(90);
        checkOutput("rally_serve", S_SERVE, e_p1, e_p2, e_dir, 1'b0);
        tickFrames(60);
        checkOutput("rally_play", S_PLAY, e_p1, e_p2, e_dir, 1'b0);
    endtask

    // Monitor: on each falling edge, compare every snapshot due for this
    // cycle. The winner bit is compared only when game_over is expected.
    // A snapshot whose cycle has already passed counts as a miscompare.
    always @(negedge clk) begin : monitor
        int    c;
        out_t  e;
        out_t  a;
        out_t  m;
        string n;
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            c = cyc_q.pop_front();
            e = exp_q.pop_front();
            n = name_q.pop_front();
            n_vec++;
            if (c != cyc) begin
                n_fail++;
                $display("[TB] FAIL %s: due at cycle %0d, sampled at %0d", n, c, cyc);
            end else begin
                a.run    = ball_run;
                a.breset = ball_reset;
                a.dir    = serve_dir;
                a.p1     = points_first_player;
                a.p2     = points_second_player;
                a.over   = game_over;
                a.win    = winner;
                a.st     = state_dbg;
                m        = '1;
                m.win    = e.over;
                if (((a ^ e) & m) != '0) begin
                    n_fail++;
                    $display("[TB] FAIL %s @%0d: got st=%0d run=%b rst=%b dir=%b p1=%0d p2=%0d over=%b win=%b; want st=%0d run=%b rst=%b dir=%b p1=%0d p2=%0d over=%b win=%b",
                             n, cyc, a.st, a.run, a.breset, a.dir, a.p1, a.p2, a.over, a.win,
                             e.st, e.run, e.breset, e.dir, e.p1, e.p2, e.over, e.win);
                end
            end
        end
    end

    // Safety net: a run that overstays its budget is reported and closed.
    initial begin
        #500000;
        n_fail++;
        $display("[TB] FAIL watchdog: time limit reached, %0d checks still queued", cyc_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        // Reset for three cycles with no buttons pressed.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", S_IDLE, 0, 0, 0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("idle_ignores_tick", S_IDLE, 0, 0, 0, 1'b0);

        // Start with btn_up. The serve lasts exactly 60 frame ticks.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start_up", S_SERVE, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tickFrames(59);
        checkOutput("serve_59", S_SERVE, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("serve_60_play", S_PLAY, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tickFrames(3);
        checkOutput("play_ignores_tick", S_PLAY, 0, 0, 0, 1'b0);

        // miss_right scores for player 1. Misses during POINT are ignored.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("miss_right", S_POINT, 1, 0, 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("point_ign_left", S_POINT, 1, 0, 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("point_ign_right", S_POINT, 1, 0, 1, 1'b0);
        tickFrames(89);
        checkOutput("point_89", S_POINT, 1, 0, 1, 1'b0);
        tickFrames(1);
        checkOutput("point_90_serve", S_SERVE, 1, 0, 1, 1'b0);
        tickFrames(60);
        checkOutput("serve_to_play", S_PLAY, 1, 0, 1, 1'b0);

        // Both misses together: miss_left wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("both_miss", S_POINT, 1, 1, 0, 1'b0);
        tickFrames(90);
        checkOutput("both_serve", S_SERVE, 1, 1, 0, 1'b0);
        tickFrames(60);
        checkOutput("both_play", S_PLAY, 1, 1, 0, 1'b0);

        // Player 2 climbs to 10, then wins with 11.
        e_p1  = 1;
        e_p2  = 1;
        e_dir = 0;
        for (int i = 0; i < 9; i++) playPoint(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("win_miss", S_POINT, 1, 11, 0, 1'b0);
        tickFrames(89);
        checkOutput("win_point_89", S_POINT, 1, 11, 0, 1'b0);
        tickFrames(1);
        checkOutput("game_over", S_OVER, 1, 11, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("over_ign_left", S_OVER, 1, 11, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("over_ign_right", S_OVER, 1, 11, 0, 1'b1);
        tickFrames(2);
        checkOutput("over_ign_tick", S_OVER, 1, 11, 0, 1'b1);

        // btn_down returns to IDLE with the scores held. The next start
        // clears them.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("over_to_idle", S_IDLE, 1, 11, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart_clears", S_SERVE, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // A button held through reset release does not start a match.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_btn_held", S_IDLE, 0, 0, 0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_no_start", S_IDLE, 0, 0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("held_no_start2", S_IDLE, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reach 5:3 in PLAY, then reset with a miss pending.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("start_down", S_SERVE, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tickFrames(60);
        checkOutput("play_again", S_PLAY, 0, 0, 0, 1'b0);
        e_p1  = 0;
        e_p2  = 0;
        e_dir = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) playPoint(1'b0, 1'b1);
            else       playPoint(1'b1, 1'b0);
        end
        checkOutput("score_5_3", S_PLAY, 5, 3, 0, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_mid_play", S_IDLE, 0, 0, 0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("after_rst", S_IDLE, 0, 0, 0, 1'b0);

        // Let the monitor drain. Anything left over was never compared.
        @(negedge clk);
        @(negedge clk);
        while (cyc_q.size() > 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL %s: never compared (due %0d)", name_q[0], cyc_q[0]);
            void'(cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
